full_adder_pipe: RTL and testbench

// - Parametrised, pipelined successor to the single-bit registered full_adder.
// - Adds two WIDTH-bit operands plus carry_in over STAGES carry-chain slices, one register stage per slice.
// - Valid/ready handshake on both sides with full backpressure; sustains one result per cycle.
// - Serves as the datapath adder for the formal/simulation flows (FPV cover and assert harnesses).

---
 rtl/full_adder_pipe.sv | 113 +++++++++++
 tb/tb_full_adder_pipe.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/full_adder_pipe.sv
// Pipelined WIDTH-bit adder: one carry-chain slice per register stage, valid/ready on both sides.
// Optional signed-overflow output is enabled by defining FULL_ADDER_PIPE_OVF_EN.
module full_adder_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef FULL_ADDER_PIPE_OVF_EN
    ,
    output logic             overflow
`endif
);
    localparam int SW = WIDTH / STAGES;

    logic adv;

    // The whole pipe moves or holds as one, so a stalled output also stalls the input.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        localparam int LO  = g * SW;
        localparam int OPW = WIDTH - LO;

        logic [OPW-1:0]   op_a;
        logic [OPW-1:0]   op_b;
        logic             op_c;
        logic             op_v;
        logic [SW:0]      res;
        logic [LO+SW-1:0] nxt_sum;
        logic             vld_q;
        logic             cry_q;
        logic [LO+SW-1:0] sum_q;

        // Operands still to be added shrink by one slice per stage; finished slices accumulate in sum_q.
        if (g == 0) begin : g_src
            assign op_a    = a;
            assign op_b    = b;
            assign op_c    = carry_in;
            assign op_v    = in_valid;
            assign nxt_sum = res[SW-1:0];
        end else begin : g_src
            assign op_a    = g_stage[g-1].g_fwd.a_q;
            assign op_b    = g_stage[g-1].g_fwd.b_q;
            assign op_c    = g_stage[g-1].cry_q;
            assign op_v    = g_stage[g-1].vld_q;
            assign nxt_sum = {res[SW-1:0], g_stage[g-1].sum_q};
        end

        assign res = {1'b0, op_a[SW-1:0]} + {1'b0, op_b[SW-1:0]} + {{SW{1'b0}}, op_c};

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                vld_q <= 1'b0;
                cry_q <= 1'b0;
                sum_q <= '0;
            end else if (adv) begin
                vld_q <= op_v;
                cry_q <= res[SW];
                sum_q <= nxt_sum;
            end
        end

        if (g < STAGES - 1) begin : g_fwd
            logic [OPW-SW-1:0] a_q;
            logic [OPW-SW-1:0] b_q;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= op_a[OPW-1:SW];
                    b_q <= op_b[OPW-1:SW];
                end
            end
        end else begin : g_tail
`ifdef FULL_ADDER_PIPE_OVF_EN
            logic msb_cin;
            logic ovf_q;

            // The carry into the MSB is recovered from the MSB sum bit and its two operand bits.
            assign msb_cin = op_a[SW-1] ^ op_b[SW-1] ^ res[SW-1];

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= msb_cin ^ res[SW];
                end
            end
`endif
        end
    end

    assign out_valid = g_stage[STAGES-1].vld_q;
    assign sum       = g_stage[STAGES-1].sum_q;
    assign carry_out = g_stage[STAGES-1].cry_q;
`ifdef FULL_ADDER_PIPE_OVF_EN
    assign overflow  = g_stage[STAGES-1].g_tail.ovf_q;
`endif

endmodule

// File: tb/tb_full_adder_pipe.sv
// Randomised and directed bench for full_adder_pipe against an integer-arithmetic reference model.
// Also exercises WIDTH=1/STAGES=1 and WIDTH=16/STAGES=4 builds; overflow checked with FULL_ADDER_PIPE_OVF_EN.
module tb_full_adder_pipe;
    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rstn;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       carry_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       carry_out;

    logic       w1_in_valid, w1_in_ready, w1_a, w1_b, w1_cin;
    logic       w1_out_valid, w1_out_ready, w1_sum, w1_cout;
    logic        w16_in_valid, w16_in_ready, w16_cin;
    logic [15:0] w16_a, w16_b, w16_sum;
    logic        w16_out_valid, w16_out_ready, w16_cout;

`ifdef FULL_ADDER_PIPE_OVF_EN
    logic overflow, w1_ovf, w16_ovf, last_ovf;
`endif

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    exp_t       model_q[$];
    int         acc_cyc[$];
    int         pop_cyc[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic       prev_stall = 1'b0;
    logic [8:0] prev_word = '0;

    full_adder_pipe #(.WIDTH(8), .STAGES(S)) u_dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .carry_in(carry_in), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry_out(carry_out)
`ifdef FULL_ADDER_PIPE_OVF_EN
        , .overflow(overflow)
`endif
    );

    full_adder_pipe #(.WIDTH(1), .STAGES(1)) u_w1 (
        .clk(clk), .rstn(rstn), .in_valid(w1_in_valid), .in_ready(w1_in_ready),
        .a(w1_a), .b(w1_b), .carry_in(w1_cin), .out_valid(w1_out_valid), .out_ready(w1_out_ready),
        .sum(w1_sum), .carry_out(w1_cout)
`ifdef FULL_ADDER_PIPE_OVF_EN
        , .overflow(w1_ovf)
`endif
    );

    full_adder_pipe #(.WIDTH(16), .STAGES(4)) u_w16 (
        .clk(clk), .rstn(rstn), .in_valid(w16_in_valid), .in_ready(w16_in_ready),
        .a(w16_a), .b(w16_b), .carry_in(w16_cin), .out_valid(w16_out_valid), .out_ready(w16_out_ready),
        .sum(w16_sum), .carry_out(w16_cout)
`ifdef FULL_ADDER_PIPE_OVF_EN
        , .overflow(w16_ovf)
`endif
    );

    always #5 clk = ~clk;

    // Reference: unsigned total gives sum/carry, signed total out of [-128,127] gives overflow.
    function automatic exp_t model_add(input logic [7:0] x, input logic [7:0] y, input logic c);
        exp_t e;
        int   total;
        int   sx;
        int   sy;
        int   st;
        total  = int'(x) + int'(y) + int'(c);
        sx     = (x >= 8'd128) ? int'(x) - 256 : int'(x);
        sy     = (y >= 8'd128) ? int'(y) - 256 : int'(y);
        st     = sx + sy + int'(c);
        e.sum  = total[7:0];
        e.cout = (total > 255);
        e.ovf  = (st > 127) || (st < -128);
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accept pushes a model result, every consume pops and compares it.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rstn) begin
            prev_stall = 1'b0;
        end else begin
            checkOutput("in_ready_rule", in_ready, !out_valid || out_ready);
            if (prev_stall) begin
                checkOutput("stall_valid", out_valid, 1);
                checkOutput("stall_hold", {carry_out, sum}, prev_word);
            end
            if (out_valid && out_ready) begin
                if (model_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL spurious_out: got sum 0x%0h with no pending op, expected none", sum);
                end else begin
                    e = model_q.pop_front();
                    checkOutput("sum", sum, e.sum);
                    checkOutput("carry_out", carry_out, e.cout);
`ifdef FULL_ADDER_PIPE_OVF_EN
                    checkOutput("overflow", overflow, e.ovf);
`endif
                end
                pop_cyc.push_back(cyc);
            end
            if (in_valid && in_ready) begin
                model_q.push_back(model_add(a, b, carry_in));
                acc_cyc.push_back(cyc);
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {carry_out, sum};
        end
    end

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (S + 3) @(posedge clk);
        #1;
    endtask

    // Single op into an idle pipe; measures latency and pins the result to literal expectations.
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                                 input logic [7:0] es, input logic ec, input string name);
        int lat;
        drain();
        a        = av;
        b        = bv;
        carry_in = cv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({name, "_latency"}, lat, S);
        checkOutput({name, "_sum"}, sum, es);
        checkOutput({name, "_cout"}, carry_out, ec);
`ifdef FULL_ADDER_PIPE_OVF_EN
        last_ovf = overflow;
`endif
    endtask

    task automatic runStream();
        drain();
        acc_cyc.delete();
        pop_cyc.delete();
        for (int i = 0; i < 16; i++) begin
            a        = 8'(i);
            b        = 8'(i);
            carry_in = 1'b1;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (S + 3) @(posedge clk);
        #1;
        checkOutput("stream_count", pop_cyc.size(), 16);
        if (pop_cyc.size() >= 16 && acc_cyc.size() >= 1) begin
            checkOutput("stream_back_to_back", pop_cyc[15] - pop_cyc[0], 15);
            checkOutput("stream_latency", pop_cyc[0] - acc_cyc[0], S);
        end
    endtask

    task automatic runBackpressure();
        logic       full;
        logic [8:0] snap;
        drain();
        full      = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            a        = 8'($urandom);
            b        = 8'($urandom);
            carry_in = 1'($urandom);
            in_valid = 1'b1;
            #1;
            if (!in_ready) begin
                full = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checkOutput("bp_fills", full, 1);
        snap = {carry_out, sum};
        repeat (5) begin
            @(posedge clk);
            #1;
            checkOutput("bp_in_ready", in_ready, 0);
            checkOutput("bp_out_valid", out_valid, 1);
            checkOutput("bp_hold", {carry_out, sum}, snap);
        end
        drain();
        checkOutput("bp_no_loss", model_q.size(), 0);
    endtask

    task automatic runRandom();
        logic took;
        took = 1'b1;
        repeat (300) begin
            if (took) begin
                in_valid = ($urandom_range(0, 9) < 7);
                a        = 8'($urandom);
                b        = 8'($urandom);
                carry_in = 1'($urandom);
            end
            out_ready = ($urandom_range(0, 9) < 6);
            @(negedge clk);
            took = !in_valid || in_ready;
            @(posedge clk);
            #1;
        end
        drain();
        checkOutput("random_drain", model_q.size(), 0);
    endtask

    task automatic runMidflightReset();
        drain();
        a = 8'h11; b = 8'h22; carry_in = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        a = 8'h33; b = 8'h44; carry_in = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("pre_reset_valid", out_valid, 1);
        #1;
        rstn = 1'b0;
        #1;
        checkOutput("mid_reset_valid", out_valid, 0);
        checkOutput("mid_reset_sum", sum, 0);
        checkOutput("mid_reset_cout", carry_out, 0);
        model_q.delete();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        applyStimulus(8'h10, 8'h20, 1'b1, 8'h31, 1'b0, "post_reset");
    endtask

    task automatic runSweep();
        int lat;
        int total;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            w1_a        = i[2];
            w1_b        = i[1];
            w1_cin      = i[0];
            w1_in_valid = 1'b1;
            @(posedge clk);
            #1;
            w1_in_valid = 1'b0;
            total = i[2] + i[1] + i[0];
            checkOutput("w1_valid", w1_out_valid, 1);
            checkOutput("w1_sum", w1_sum, total % 2);
            checkOutput("w1_cout", w1_cout, total / 2);
            if (i == 7) begin
                checkOutput("w1_111_sum", w1_sum, 1);
                checkOutput("w1_111_cout", w1_cout, 1);
            end
        end
        for (int j = 0; j < 4; j++) begin
            @(posedge clk);
            #1;
            w16_a        = (j == 0) ? 16'hFFFF : 16'($urandom);
            w16_b        = (j == 0) ? 16'h0000 : 16'($urandom);
            w16_cin      = (j == 0) ? 1'b1 : 1'($urandom);
            w16_in_valid = 1'b1;
            total = int'(w16_a) + int'(w16_b) + int'(w16_cin);
            @(posedge clk);
            #1;
            w16_in_valid = 1'b0;
            lat = 1;
            while (!w16_out_valid && lat < 10) begin
                @(posedge clk);
                #1;
                lat++;
            end
            checkOutput("w16_latency", lat, 4);
            checkOutput("w16_sum", w16_sum, total[15:0]);
            checkOutput("w16_cout", w16_cout, total[16]);
            if (j == 0) begin
                checkOutput("w16_ffff_sum", w16_sum, 16'h0000);
                checkOutput("w16_ffff_cout", w16_cout, 1);
            end
            repeat (5) @(posedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time limit reached before completion, expected $finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rstn          = 1'b0;
        in_valid      = 1'b0;
        out_ready     = 1'b1;
        a             = '0;
        b             = '0;
        carry_in      = 1'b0;
        w1_in_valid   = 1'b0;
        w1_out_ready  = 1'b1;
        w1_a          = 1'b0;
        w1_b          = 1'b0;
        w1_cin        = 1'b0;
        w16_in_valid  = 1'b0;
        w16_out_ready = 1'b1;
        w16_a         = '0;
        w16_b         = '0;
        w16_cin       = 1'b0;
        #3;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_sum", sum, 0);
        checkOutput("reset_cout", carry_out, 0);
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_w16_valid", w16_out_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;

        applyStimulus(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ff_plus_01");
`ifdef FULL_ADDER_PIPE_OVF_EN
        checkOutput("ff_plus_01_ovf", last_ovf, 0);
`endif
        applyStimulus(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, "7f_plus_01");
`ifdef FULL_ADDER_PIPE_OVF_EN
        checkOutput("7f_plus_01_ovf", last_ovf, 1);
`endif
        applyStimulus(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "80_plus_80");
`ifdef FULL_ADDER_PIPE_OVF_EN
        checkOutput("80_plus_80_ovf", last_ovf, 1);
`endif

        runStream();
        runBackpressure();
        runRandom();
        runMidflightReset();
        runSweep();
        drain();
        checkOutput("final_drain", model_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
